// File: rtl/psum_ofifo_pkg.sv
// ============================================================================
// psum_ofifo_pkg
// ----------------------------------------------------------------------------
// Shared constants and types for the psum output buffer that sits directly
// downstream of a mac_col instance.
//
// Contents:
//   BW_PSUM       psum width (2*bw+4 with bw=8), shared with mac_col
//   psum_t        signed two's-complement psum type, shared with mac_col
//   OFIFO_DEPTH   number of FIFO entries (power of two, >= 2)
//   OFIFO_ADDR_W  log2(OFIFO_DEPTH), width of the read/write pointers
//   SUM_BW        width of the saturating |psum| accumulator
// ============================================================================
package psum_ofifo_pkg;

    localparam int BW_PSUM      = 20;
    typedef logic signed [BW_PSUM-1:0] psum_t;

    localparam int OFIFO_DEPTH  = 16;
    localparam int OFIFO_ADDR_W = 4;

    // Four guard bits over the psum width, so up to 16 worst-case magnitudes
    // fit before saturation kicks in.
    localparam int SUM_BW       = BW_PSUM + 4;

endpackage : psum_ofifo_pkg

// File: rtl/psum_abs_sat_acc.sv
// ============================================================================
// psum_abs_sat_acc
// ----------------------------------------------------------------------------
// Absolute value of an incoming psum plus a saturating accumulator of those
// magnitudes. The accumulated value is the normalization denominator used by
// the stage downstream of the output FIFO.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset, clears abs_sum
//   in_psum  in   [bw_psum-1:0] two's-complement psum
//   acc_en   in   add |in_psum| this edge (write was accepted by the FIFO)
//   sum_clr  in   synchronous clear; combined with acc_en, clear then add
//   abs_sum  out  [sum_bw-1:0] saturating running sum of magnitudes
// ============================================================================
module psum_abs_sat_acc
    import psum_ofifo_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int sum_bw  = SUM_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw_psum-1:0] in_psum,
    input  logic               acc_en,
    input  logic               sum_clr,
    output logic [sum_bw-1:0]  abs_sum
);

    logic [bw_psum-1:0] mag;
    logic [sum_bw-1:0]  base;
    logic [sum_bw:0]    wide_sum;
    logic [sum_bw-1:0]  sat_sum;

    // Magnitude is kept as an unsigned bw_psum-bit quantity. The most
    // negative psum negates to itself in bit pattern, which read as unsigned
    // is exactly 2^(bw_psum-1), the correct magnitude.
    always_comb begin
        mag = in_psum;
        if (in_psum[bw_psum-1]) begin
            mag = (~in_psum) + bw_psum'(1);
        end
    end

    // A clear in the same cycle as an accepted write restarts the sum from
    // zero before adding, so the new value is just this write's magnitude.
    // One extra carry bit detects overflow past the top of the range, which
    // pins the result at all-ones; once pinned it stays there because any
    // further non-negative addend carries out again.
    always_comb begin
        base     = sum_clr ? '0 : abs_sum;
        wide_sum = {1'b0, base} + (sum_bw + 1)'(mag);
        sat_sum  = wide_sum[sum_bw] ? '1 : wide_sum[sum_bw-1:0];
    end

    // Accumulator register: reset clears, an accepted write loads the
    // saturated sum (which already honours sum_clr), a lone clear zeroes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abs_sum <= '0;
        end else if (acc_en) begin
            abs_sum <= sat_sum;
        end else if (sum_clr) begin
            abs_sum <= '0;
        end
    end

endmodule : psum_abs_sat_acc

// File: rtl/psum_ofifo.sv
// ============================================================================
// psum_ofifo
// ----------------------------------------------------------------------------
// Output-side first-word-fall-through FIFO behind one mac_col. Captures every
// psum the column emits, in stream order, so the consumer can drain at its
// own pace, and keeps a saturating sum of |psum| over accepted entries.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   in_psum    in   [bw_psum-1:0] psum from mac_col
//   in_valid   in   qualifies in_psum
//   in_ready   out  !full
//   rd_en      in   consumer pop request
//   out_psum   out  [bw_psum-1:0] head entry, 0 when empty
//   out_valid  out  !empty
//   count      out  [addr_w:0] occupancy, 0..depth
//   full       out  count == depth
//   empty      out  count == 0
//   sum_clr    in   synchronous clear of abs_sum and overflow
//   abs_sum    out  [sum_bw-1:0] saturating sum of |in_psum|
//   overflow   out  sticky flag, in_valid seen while full
// ============================================================================
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int bw_psum = BW_PSUM,
    parameter int depth   = OFIFO_DEPTH,
    parameter int addr_w  = OFIFO_ADDR_W,
    parameter int sum_bw  = SUM_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw_psum-1:0] in_psum,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rd_en,
    output logic [bw_psum-1:0] out_psum,
    output logic               out_valid,
    output logic [addr_w:0]    count,
    output logic               full,
    output logic               empty,
    input  logic               sum_clr,
    output logic [sum_bw-1:0]  abs_sum,
    output logic               overflow
);

    localparam logic [addr_w:0] DEPTH_CNT = (addr_w + 1)'(depth);

    logic [bw_psum-1:0] mem [depth];
    logic [addr_w-1:0]  wr_ptr;
    logic [addr_w-1:0]  rd_ptr;
    logic               wr_acc;
    logic               rd_acc;

    // Status flags come straight from compares on the registered count.
    // Tracking count separately from the pointers keeps full and empty
    // unambiguous when the pointers are equal.
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Both accept decisions use the pre-edge flags, so a pop in the same
    // cycle cannot make room for a write that arrives while full.
    assign wr_acc = in_valid && !full;
    assign rd_acc = rd_en && !empty;

    // Head entry falls through combinationally; forced to zero when empty so
    // stale memory contents never leak onto the output.
    assign out_psum = empty ? '0 : mem[rd_ptr];

    // Storage array. Not reset: a location is only ever read after it has
    // been written, since count gates the read side.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= in_psum;
        end
    end

    // Pointers wrap naturally at addr_w bits because depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + addr_w'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + addr_w'(1);
            end
        end
    end

    // Occupancy: a simultaneous accepted read and write leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (addr_w + 1)'(1);
                2'b01:   count <= count - (addr_w + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow. A dropped write in the same cycle as sum_clr still
    // sets the flag, so the set branch is checked first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && full) begin
            overflow <= 1'b1;
        end else if (sum_clr) begin
            overflow <= 1'b0;
        end
    end

    psum_abs_sat_acc #(
        .bw_psum (bw_psum),
        .sum_bw  (sum_bw)
    ) u_abs_acc (
        .clk     (clk),
        .reset   (reset),
        .in_psum (in_psum),
        .acc_en  (wr_acc),
        .sum_clr (sum_clr),
        .abs_sum (abs_sum)
    );

endmodule : psum_ofifo
